// File: rtl/bridge_pkg.sv
// -----------------------------------------------------------------------------
// bridge_pkg
// Shared definitions for the drawbridge signal sequencer:
//   - state_e      : sequencer states (GO, WARN, STOP, RUN, FAULT)
//   - lamp_t       : road lamp vector {red, yellow, green}, one-hot
//   - DEF_*        : default timing constants, also used by the state
//                    decoder's testbench
//   - lamp_for_state : maps a state to its lamp pattern
// -----------------------------------------------------------------------------
package bridge_pkg;

  typedef enum logic [2:0] {
    ST_GO    = 3'd0,
    ST_WARN  = 3'd1,
    ST_STOP  = 3'd2,
    ST_RUN   = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  // Lamp vector bit order: {red, yellow, green}
  typedef logic [2:0] lamp_t;

  localparam lamp_t LAMP_GREEN  = 3'b001;
  localparam lamp_t LAMP_YELLOW = 3'b010;
  localparam lamp_t LAMP_RED    = 3'b100;

  localparam int DEF_TICK_DIV        = 50_000_000;
  localparam int DEF_YELLOW_TICKS    = 3;
  localparam int DEF_CLEAR_TICKS     = 5;
  localparam int DEF_BLINK_TICKS     = 1;
  localparam int DEF_MOTOR_MAX_TICKS = 30;

  // Every state other than GO and WARN keeps the road closed, including any
  // unexpected encoding.
  function automatic lamp_t lamp_for_state(input state_e st);
    case (st)
      ST_GO:   lamp_for_state = LAMP_GREEN;
      ST_WARN: lamp_for_state = LAMP_YELLOW;
      default: lamp_for_state = LAMP_RED;
    endcase
  endfunction

endpackage

// File: rtl/bridge_signal_sequencer_if.sv
// -----------------------------------------------------------------------------
// bridge_signal_sequencer_if
// Command and actuator signals between the bridge state decoder and the
// signal sequencer.
//   Commands  : MT (motor), AL (alarm), TFL (traffic stop request)
//   Actuators : LGreen, LYellow, LRed, MotorEn, Buzzer, Fault
// master = decoder side (drives commands), slave = sequencer side.
// -----------------------------------------------------------------------------
interface bridge_signal_sequencer_if;

  logic MT;
  logic AL;
  logic TFL;
  logic LGreen;
  logic LYellow;
  logic LRed;
  logic MotorEn;
  logic Buzzer;
  logic Fault;

  modport master (
    output MT, AL, TFL,
    input  LGreen, LYellow, LRed, MotorEn, Buzzer, Fault
  );

  modport slave (
    input  MT, AL, TFL,
    output LGreen, LYellow, LRed, MotorEn, Buzzer, Fault
  );

endinterface

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Free-running prescaler counting 0..TICK_DIV-1; Tick is high while the
// count sits on its terminal value. Clear restarts the count so the next
// tick arrives exactly TICK_DIV cycles later.
//   Clock  : system clock
//   Reset  : synchronous, active-high
//   Clear  : synchronous restart of the prescaler
//   Tick   : one cycle in every TICK_DIV
// -----------------------------------------------------------------------------
module tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Clear,
  output logic Tick
);

  localparam int CW = $clog2(TICK_DIV + 1);
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next prescaler value: restart on Clear or after the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (Clear) begin
      cnt_d = '0;
    end else if (cnt_q >= TERM) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Tick = (cnt_q == TERM);

endmodule

// File: rtl/bridge_signal_sequencer.sv
// -----------------------------------------------------------------------------
// bridge_signal_sequencer
// Road lamp sequencing, motor gating, alarm buzzer and motor-overrun fault
// for the drawbridge.
//   Clock   : system clock, rising edge
//   Reset   : synchronous, active-high, overrides everything (incl. FAULT)
//   bus     : slave side of bridge_signal_sequencer_if
//             in  MT, AL, TFL
//             out LGreen, LYellow, LRed, MotorEn, Buzzer, Fault (registered)
// All outputs are registered from next-state values, so they line up with
// the state register and change one cycle after the causing input.
// -----------------------------------------------------------------------------
module bridge_signal_sequencer
  import bridge_pkg::*;
#(
  parameter int TICK_DIV        = DEF_TICK_DIV,
  parameter int YELLOW_TICKS    = DEF_YELLOW_TICKS,
  parameter int CLEAR_TICKS     = DEF_CLEAR_TICKS,
  parameter int BLINK_TICKS     = DEF_BLINK_TICKS,
  parameter int MOTOR_MAX_TICKS = DEF_MOTOR_MAX_TICKS
) (
  input  logic                       Clock,
  input  logic                       Reset,
  bridge_signal_sequencer_if.slave   bus
);

  localparam int SEQ_MAX = (YELLOW_TICKS > CLEAR_TICKS) ? YELLOW_TICKS : CLEAR_TICKS;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam int RUN_W   = $clog2(MOTOR_MAX_TICKS + 1);
  localparam int BLK_W   = $clog2(BLINK_TICKS + 1);

  localparam logic [SEQ_W-1:0] YELLOW_LOAD = SEQ_W'(YELLOW_TICKS);
  localparam logic [SEQ_W-1:0] CLEAR_LOAD  = SEQ_W'(CLEAR_TICKS);
  localparam logic [RUN_W-1:0] RUN_LIMIT   = RUN_W'(MOTOR_MAX_TICKS);
  localparam logic [BLK_W-1:0] BLINK_LAST  = BLK_W'(BLINK_TICKS - 1);

  logic mt_s;
  logic al_s;
  logic tfl_s;

  state_e           state_q, state_d;
  logic [SEQ_W-1:0] seq_cnt_q, seq_cnt_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;
  logic             al_q;

  lamp_t            lamp_q;
  logic             motor_en_q;
  logic             buzzer_q;
  logic             fault_q;

  logic             state_tick_s;
  logic             state_clear_s;
  logic             blink_tick_s;
  logic             blink_clear_s;
  logic             al_rise_s;
  logic             stop_done_s;

  assign mt_s  = bus.MT;
  assign al_s  = bus.AL;
  assign tfl_s = bus.TFL;

  // Each timed state starts with a fresh prescaler so it lasts N*TICK_DIV cycles.
  assign state_clear_s = (state_d != state_q);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_state_tick (
    .Clock (Clock),
    .Reset (Reset),
    .Clear (state_clear_s),
    .Tick  (state_tick_s)
  );

  // Blink timing restarts on the AL rise and idles while AL is low.
  assign al_rise_s     = al_s & ~al_q;
  assign blink_clear_s = al_rise_s | ~al_s;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_blink_tick (
    .Clock (Clock),
    .Reset (Reset),
    .Clear (blink_clear_s),
    .Tick  (blink_tick_s)
  );

  // Clearance is complete when the count is already parked at zero or the
  // current tick takes it there.
  assign stop_done_s = (seq_cnt_q == '0) ||
                       (state_tick_s && (seq_cnt_q == SEQ_W'(1)));

  // Next-state logic for the lamp/motor sequence and its counters.
  always_comb begin
    state_d   = state_q;
    seq_cnt_d = seq_cnt_q;
    run_cnt_d = run_cnt_q;
    case (state_q)
      ST_GO: begin
        run_cnt_d = '0;
        // MT is deliberately ignored here; the motor waits for RUN.
        if (tfl_s) begin
          state_d   = ST_WARN;
          seq_cnt_d = YELLOW_LOAD;
        end else begin
          seq_cnt_d = '0;
        end
      end
      ST_WARN: begin
        run_cnt_d = '0;
        // Runs to completion regardless of TFL.
        if (state_tick_s) begin
          if (seq_cnt_q <= SEQ_W'(1)) begin
            state_d   = ST_STOP;
            seq_cnt_d = CLEAR_LOAD;
          end else begin
            seq_cnt_d = seq_cnt_q - SEQ_W'(1);
          end
        end else begin
          seq_cnt_d = seq_cnt_q;
        end
      end
      ST_STOP: begin
        run_cnt_d = '0;
        if (stop_done_s) begin
          seq_cnt_d = '0;
          if (mt_s) begin
            state_d = ST_RUN;
          end else if (!tfl_s) begin
            state_d = ST_GO;
          end else begin
            state_d = ST_STOP;
          end
        end else if (state_tick_s) begin
          seq_cnt_d = seq_cnt_q - SEQ_W'(1);
        end else begin
          seq_cnt_d = seq_cnt_q;
        end
      end
      ST_RUN: begin
        // A counter that has hit its limit trips even if MT has just dropped.
        if (run_cnt_q >= RUN_LIMIT) begin
          state_d = ST_FAULT;
        end else if (!mt_s) begin
          run_cnt_d = '0;
          if (!tfl_s) begin
            state_d = ST_GO;
          end else begin
            state_d = ST_RUN;
          end
        end else if (state_tick_s) begin
          run_cnt_d = run_cnt_q + RUN_W'(1);
        end else begin
          run_cnt_d = run_cnt_q;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

  // Next buzzer blink phase: high straight after an AL rise, toggling every
  // BLINK_TICKS ticks, forced low when AL drops.
  always_comb begin
    phase_d     = phase_q;
    blink_cnt_d = blink_cnt_q;
    if (!al_s) begin
      phase_d     = 1'b0;
      blink_cnt_d = '0;
    end else if (al_rise_s) begin
      phase_d     = 1'b1;
      blink_cnt_d = '0;
    end else if (blink_tick_s) begin
      if (blink_cnt_q >= BLINK_LAST) begin
        phase_d     = ~phase_q;
        blink_cnt_d = '0;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end else begin
      phase_d = phase_q;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= ST_GO;
      seq_cnt_q   <= '0;
      run_cnt_q   <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      al_q        <= 1'b0;
      lamp_q      <= LAMP_GREEN;
      motor_en_q  <= 1'b0;
      buzzer_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_cnt_q   <= seq_cnt_d;
      run_cnt_q   <= run_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      al_q        <= al_s;
      lamp_q      <= lamp_for_state(state_d);
      motor_en_q  <= (state_d == ST_RUN) && mt_s;
      buzzer_q    <= (state_d == ST_FAULT) ? 1'b1 : phase_d;
      fault_q     <= (state_d == ST_FAULT);
    end
  end

  assign bus.LGreen  = lamp_q[0];
  assign bus.LYellow = lamp_q[1];
  assign bus.LRed    = lamp_q[2];
  assign bus.MotorEn = motor_en_q;
  assign bus.Buzzer  = buzzer_q;
  assign bus.Fault   = fault_q;

endmodule
